cpu_control_unit_p: RTL and testbench

Parametrised successor to the 8-bit CPU control unit. Fetch/decode/execute sequencer with an internal register file, an inline ALU and a status register (Z, C). It fetches from an external instruction memory over a req/valid handshake. Over the 8-bit unit it adds data-memory load/store over a req/ready handshake, absolute and conditional jumps, and a HALT state. Sits at the CPU top, between the program ROM and the data RAM.

---
 rtl/cpu_control_unit_p_if.sv | 25 ++
 rtl/cpu_control_unit_p.sv | 120 ++++++++++++
 tb/tb_cpu_control_unit_p.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_unit_p_if.sv
// cpu_control_unit_p_if: instruction-fetch and data-memory buses of the control unit.
interface cpu_control_unit_p_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 4,
    parameter int AW     = 4
);
    logic                    imem_req;
    logic [PC_W-1:0]         imem_addr;
    logic [4+2*DATA_W-1:0]   imem_data;
    logic                    imem_valid;
    logic                    dmem_req;
    logic                    dmem_we;
    logic [AW-1:0]           dmem_addr;
    logic [DATA_W-1:0]       dmem_wdata;
    logic [DATA_W-1:0]       dmem_rdata;
    logic                    dmem_ready;
    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_data, imem_valid, dmem_rdata, dmem_ready
    );
    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_data, imem_valid, dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/cpu_control_unit_p.sv
// cpu_control_unit_p: fetch/decode/execute sequencer with register file, ALU, flags,
// data-memory load/store, jumps and a terminal HALT state.
module cpu_control_unit_p #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int PC_W   = 4,
    parameter int AW     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    cpu_control_unit_p_if.master    bus,
    output logic                    halted,
    output logic [2:0]              cpu_state,
    output logic [PC_W-1:0]         pc_debug,
    output logic [NREGS*DATA_W-1:0] reg_file_out,
    output logic [1:0]              sreg_out
);
    localparam int RW = $clog2(NREGS);
    typedef enum logic [2:0] {S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_HALT = 3'd4} state_t;
    state_t                r_state, w_next;
    logic [PC_W-1:0]       r_pc;
    logic [DATA_W-1:0]     r_regs [NREGS];
    logic                  r_z, r_c;
    logic [4+2*DATA_W-1:0] r_ir;
    logic [DATA_W-1:0]     r_opa, r_opb;
    logic                  r_dreq, r_dwe;
    logic [AW-1:0]         r_daddr;
    logic [DATA_W-1:0]     r_dwdata;
    logic [3:0]            w_opc;
    logic [DATA_W-1:0]     w_op1, w_op2;
    logic [RW-1:0]         w_rd, w_rs;
    logic [DATA_W:0]       w_res;
    logic                  w_alu, w_mem, w_unused;
    assign {w_opc, w_op1, w_op2} = r_ir;
    assign w_rd     = w_op1[RW-1:0];
    assign w_rs     = w_op2[RW-1:0];
    assign w_alu    = w_opc >= 4'd2 && w_opc <= 4'd6;
    assign w_mem    = w_opc == 4'd7 || w_opc == 4'd8;
    assign w_unused = &{1'b0, w_op1};
    // Top bit carries ADD carry-out / SUB borrow; logic ops leave it clear.
    assign w_res = w_opc == 4'd2 ? {1'b0, r_opa} + {1'b0, r_opb} :
                   w_opc == 4'd3 ? {1'b0, r_opa} - {1'b0, r_opb} :
                   w_opc == 4'd4 ? {1'b0, r_opa & r_opb} :
                   w_opc == 4'd5 ? {1'b0, r_opa | r_opb} : {1'b0, r_opa ^ r_opb};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = bus.imem_valid ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_opc == 4'd15 ? S_HALT : S_EXEC;
            S_EXEC:   w_next = w_mem ? S_MEM : S_FETCH;
            S_MEM:    w_next = bus.dmem_ready ? S_FETCH : S_MEM;
            default:  w_next = r_state;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_ir     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_dreq   <= 1'b0;
            r_dwe    <= 1'b0;
            r_daddr  <= '0;
            r_dwdata <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (bus.imem_valid) begin
                    r_ir <= bus.imem_data;
                    r_pc <= r_pc + PC_W'(1);
                end
                S_DECODE: begin
                    r_opa <= r_regs[w_rd];
                    r_opb <= r_regs[w_rs];
                end
                S_EXEC: begin
                    if (w_alu) begin
                        r_regs[w_rd] <= w_res[DATA_W-1:0];
                        r_z          <= w_res[DATA_W-1:0] == '0;
                        r_c          <= w_res[DATA_W];
                    end
                    if (w_opc == 4'd1) r_regs[w_rd] <= w_op2;
                    if (w_opc == 4'd9 || (w_opc == 4'd10 && r_z)) r_pc <= w_op1[PC_W-1:0];
                    if (w_mem) begin
                        r_dreq   <= 1'b1;
                        r_dwe    <= w_opc == 4'd8;
                        r_daddr  <= w_op2[AW-1:0];
                        r_dwdata <= r_opa;
                    end
                end
                S_MEM: if (bus.dmem_ready) begin
                    r_dreq <= 1'b0;
                    r_dwe  <= 1'b0;
                    if (!r_dwe) r_regs[w_rd] <= bus.dmem_rdata;
                end
                default: ;
            endcase
        end
    end
    // Fetch request is gated by rst so it drops the moment reset asserts.
    assign bus.imem_req   = r_state == S_FETCH && !rst;
    assign bus.imem_addr  = r_pc;
    assign bus.dmem_req   = r_dreq;
    assign bus.dmem_we    = r_dwe;
    assign bus.dmem_addr  = r_daddr;
    assign bus.dmem_wdata = r_dwdata;
    assign halted         = r_state == S_HALT;
    assign cpu_state      = r_state;
    assign pc_debug       = r_pc;
    assign sreg_out       = {r_c, r_z};
    for (genvar g = 0; g < NREGS; g++) begin : g_rf
        assign reg_file_out[g*DATA_W +: DATA_W] = r_regs[g];
    end
endmodule

// File: tb/tb_cpu_control_unit_p.sv
// tb_cpu_control_unit_p: directed and randomized programs checked instruction by
// instruction against an ISA-level reference model.
module tb_cpu_control_unit_p;
    localparam int DATA_W = 8, NREGS = 8, PC_W = 4, AW = 4;
    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    halted;
    logic [2:0]              cpu_state;
    logic [PC_W-1:0]         pc_debug;
    logic [NREGS*DATA_W-1:0] reg_file_out;
    logic [1:0]              sreg_out;
    cpu_control_unit_p_if #(.DATA_W(DATA_W), .PC_W(PC_W), .AW(AW)) bus ();
    cpu_control_unit_p #(.DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W), .AW(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .halted(halted), .cpu_state(cpu_state),
        .pc_debug(pc_debug), .reg_file_out(reg_file_out), .sreg_out(sreg_out)
    );
    always #5 clk = ~clk;
    logic [19:0] prog [16];
    int  dut_mem [16];
    int  m_mem [16];
    int  m_r [8];
    int  m_pc;
    bit  m_z, m_c;
    int  lat = 1, cnt = 0;
    bit  rnd_valid = 1'b0, force_lo = 1'b0;
    int  n_chk = 0, n_pass = 0;
    int  st_cyc, st_bad, ld_early, cyc;
    assign bus.imem_data = prog[bus.imem_addr];
    // Memory responder: ready rises on the lat-th cycle of a request.
    always @(negedge clk) begin
        bus.imem_valid = force_lo ? 1'b0 : rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (rst) dut_mem = m_mem;
        if (rst || bus.dmem_ready) begin
            bus.dmem_ready = 1'b0;
            bus.dmem_rdata = 8'($urandom);
            cnt = 0;
        end else if (bus.dmem_req) begin
            cnt++;
            if (cnt >= lat) begin
                bus.dmem_ready = 1'b1;
                if (bus.dmem_we) dut_mem[bus.dmem_addr] = int'(bus.dmem_wdata);
                else bus.dmem_rdata = 8'(dut_mem[bus.dmem_addr]);
            end
        end
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    function automatic logic [19:0] ins(input int op, input int a, input int b);
        return {op[3:0], a[7:0], b[7:0]};
    endfunction
    function automatic logic [63:0] m_regs();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(m_r[i]);
        return v;
    endfunction
    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = '0;
    endtask
    task automatic model_step(output bit h);
        logic [19:0] w;
        int op, a, b, rd, x, y, r;
        w  = prog[m_pc];
        op = int'(w[19:16]);
        a  = int'(w[15:8]);
        b  = int'(w[7:0]);
        rd = a % 8;
        x  = m_r[rd];
        y  = m_r[b % 8];
        h  = 1'b0;
        m_pc = (m_pc + 1) % 16;
        case (op)
            1: m_r[rd] = b;
            2, 3, 4, 5, 6: begin
                r = op == 2 ? x + y : op == 3 ? x - y : op == 4 ? (x & y) : op == 5 ? (x | y) : (x ^ y);
                m_c = op == 2 ? (r > 255) : op == 3 ? (x < y) : 1'b0;
                r = (r + 256) % 256;
                m_r[rd] = r;
                m_z = r == 0;
            end
            7: m_r[rd] = m_mem[b % 16];
            8: m_mem[b % 16] = x;
            9: m_pc = a % 16;
            10: if (m_z) m_pc = a % 16;
            15: h = 1'b1;
            default: ;
        endcase
    endtask
    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_state", cpu_state, 0);
        chk("rst_pc", pc_debug, 0);
        chk("rst_dmem", {bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}, 0);
        chk("rst_halted", halted, 0);
        chk("rst_regs", reg_file_out, 0);
        chk("rst_sreg", sreg_out, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        m_pc = 0;
        m_z  = 1'b0;
        m_c  = 1'b0;
        for (int i = 0; i < 8; i++) m_r[i] = 0;
    endtask
    // Steps the model at every DUT instruction retirement and compares architectural state.
    task automatic run_prog(input int n);
        int prev, st, retired;
        bit h, done;
        prev = 0; retired = 0; done = 1'b0;
        cyc = 0; st_cyc = 0; st_bad = 0; ld_early = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            cyc++;
            st = int'(cpu_state);
            if (bus.dmem_req && bus.dmem_we) begin
                st_cyc++;
                if (bus.dmem_addr != 4'd2 || bus.dmem_wdata != 8'h5A) st_bad++;
            end
            if (bus.dmem_req && !bus.dmem_we && reg_file_out[39:32] != 8'h00) ld_early++;
            if ((st == 0 && (prev == 2 || prev == 3)) || (st == 4 && prev == 1)) begin
                model_step(h);
                retired++;
                chk("pc", pc_debug, m_pc);
                chk("regs", reg_file_out, m_regs());
                chk("sreg", sreg_out, {m_c, m_z});
                chk("halted", halted, h);
                done = h || retired >= n;
            end
            if (cyc >= 2000) begin
                chk("timeout_retired", retired, n);
                done = 1'b1;
            end
            prev = st;
        end
    endtask
    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        // Straight-line ADD then STOP: 11 cycles to HALT, then frozen.
        clear_prog();
        prog[0] = ins(1, 1, 5); prog[1] = ins(1, 2, 3); prog[2] = ins(2, 1, 2); prog[3] = ins(15, 0, 0);
        do_reset();
        run_prog(10);
        chk("t2_cycles", cyc, 11);
        chk("t2_r1", reg_file_out[15:8], 8);
        chk("t2_sreg", sreg_out, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_pc_frozen", pc_debug, 4);
        chk("t2_state_halt", cpu_state, 4);
        chk("t2_no_req", {bus.imem_req, bus.dmem_req}, 0);
        // Carry on ADD overflow, then zero/borrow-free SUB of a register with itself.
        clear_prog();
        prog[0] = ins(1, 0, 200); prog[1] = ins(1, 1, 100); prog[2] = ins(2, 0, 1);
        prog[3] = ins(3, 1, 1); prog[4] = ins(15, 0, 0);
        do_reset();
        run_prog(3);
        chk("t3_r0", reg_file_out[7:0], 44);
        chk("t3_add_sreg", sreg_out, 2'b10);
        run_prog(2);
        chk("t3_r1", reg_file_out[15:8], 0);
        chk("t3_sub_sreg", sreg_out, 2'b01);
        // Store then load with three wait cycles each.
        clear_prog();
        prog[0] = ins(1, 3, 8'h5A); prog[1] = ins(8, 3, 2); prog[2] = ins(7, 4, 2); prog[3] = ins(15, 0, 0);
        lat = 3;
        do_reset();
        run_prog(10);
        chk("t4_cycles", cyc, 17);
        chk("t4_st_req_cycles", st_cyc, 3);
        chk("t4_st_unstable", st_bad, 0);
        chk("t4_ld_early_write", ld_early, 0);
        chk("t4_r4", reg_file_out[39:32], 8'h5A);
        chk("t4_mem2", dut_mem[2], 8'h5A);
        // Taken and not-taken JZ, JMP to 15, straight-line wrap from 15 to 0.
        clear_prog();
        lat = 1;
        prog[0] = ins(1, 0, 1); prog[1] = ins(3, 0, 0); prog[2] = ins(10, 7, 0);
        prog[7] = ins(1, 1, 9); prog[8] = ins(2, 1, 1); prog[9] = ins(10, 7, 0);
        prog[10] = ins(9, 15, 0); prog[15] = ins(1, 2, 3);
        do_reset();
        run_prog(8);
        chk("t5_wrap_pc", pc_debug, 0);
        clear_prog();
        prog[0] = ins(9, 15, 0); prog[15] = ins(9, 0, 0);
        do_reset();
        run_prog(2);
        chk("t5_jmp0_pc", pc_debug, 0);
        // Fetch stall, then opcode 12 behaving as NOP.
        clear_prog();
        prog[0] = ins(1, 1, 8'h80); prog[1] = ins(2, 1, 1); prog[2] = ins(12, 1, 8'h55); prog[3] = ins(15, 0, 0);
        force_lo = 1'b1;
        do_reset();
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("t6_stall_req", bus.imem_req, 1);
            chk("t6_stall_addr", bus.imem_addr, 0);
            chk("t6_stall_state", cpu_state, 0);
        end
        force_lo = 1'b0;
        run_prog(10);
        chk("t6_r1", reg_file_out[15:8], 0);
        chk("t6_sreg", sreg_out, 2'b11);
        // Random programs with random fetch stalls and memory latencies.
        rnd_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 16; i++) begin
                prog[i]  = ins(($urandom_range(0, 39) == 0) ? 15 : $urandom_range(0, 14),
                               $urandom_range(0, 255), $urandom_range(0, 255));
                m_mem[i] = $urandom_range(0, 255);
            end
            lat = $urandom_range(1, 4);
            do_reset();
            run_prog(40);
            for (int i = 0; i < 16; i++) chk("rnd_mem", dut_mem[i], m_mem[i]);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
